// File: rtl/pe_post_proc.sv
// pe_post_proc: PE result post-processing (bias, optional ReLU, shift, saturate) with framed valid/ready FIFO output
//
// Optional feature macro: PE_POST_RELU_EN
//   defined   -> negative sums clamp to 0, output saturates unsigned [0, 2^OUT_W-1]
//   undefined -> output is signed, saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   clr         synchronous clear of pipeline, FIFO, frame counter, ovf_err
//   pe_data     unsigned PE accumulated sum (2*DATA_WIDTH bits)
//   pe_ready    1-cycle PE result strobe
//   cfg_bias    signed bias added to each sum
//   cfg_shift   arithmetic right shift, 0..15
//   m_valid     output word available
//   m_ready     downstream accepts
//   m_data      post-processed result
//   m_last      m_data is the last result of its frame
//   fifo_level  FIFO occupancy
//   ovf_err     sticky: a result was dropped on a full FIFO
module pe_post_proc #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_W      = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int FRAME_LEN  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic [2*DATA_WIDTH-1:0]       pe_data,
  input  logic                          pe_ready,
  input  logic [2*DATA_WIDTH-1:0]       cfg_bias,
  input  logic [3:0]                    cfg_shift,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [OUT_W-1:0]              m_data,
  output logic                          m_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf_err
);
  localparam int SW = 2*DATA_WIDTH+2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
`ifdef PE_POST_RELU_EN
  localparam bit RELU = 1'b1;
  localparam logic signed [SW-1:0] HI = SW'((1 << OUT_W) - 1);
  localparam logic signed [SW-1:0] LO = '0;
`else
  localparam bit RELU = 1'b0;
  localparam logic signed [SW-1:0] HI = SW'((1 << (OUT_W-1)) - 1);
  localparam logic signed [SW-1:0] LO = ~HI;
`endif
  logic                    s1_v, s2_v, s2_l;
  logic signed [SW-1:0]    s1, r, sh, sat;
  logic [3:0]              s1_shift;
  logic [OUT_W-1:0]        s2_d;
  logic [FW-1:0]           fcnt;
  logic                    f_last;
  logic [OUT_W:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             count;
  logic                    pop, full, push, drop, nxt_valid;
  always_comb begin
    r         = RELU && s1[SW-1] ? '0 : s1;
    sh        = r >>> s1_shift;
    sat       = sh > HI ? HI : sh < LO ? LO : sh;
    f_last    = fcnt == FW'(FRAME_LEN-1);
    pop       = m_valid & m_ready;
    full      = count == (AW+1)'(FIFO_DEPTH);
    // a pop in the same cycle frees the slot a full-FIFO push needs
    push      = s2_v & (~full | pop);
    drop      = s2_v & full & ~pop;
    // the head register only ever shows entries already stored before this edge
    nxt_valid = count != (AW+1)'(pop);
  end
  // S1 sums with the bias; S2 post-processes and tags frame position
  // (the frame counter counts every S2 result, dropped or not, so alignment survives overflow)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v     <= 1'b0;
      s1       <= '0;
      s1_shift <= '0;
      s2_v     <= 1'b0;
      s2_d     <= '0;
      s2_l     <= 1'b0;
      fcnt     <= '0;
    end else if (clr) begin
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      fcnt     <= '0;
    end else begin
      s1_v <= pe_ready;
      if (pe_ready) begin
        s1       <= $signed({2'b00, pe_data}) + $signed({{2{cfg_bias[2*DATA_WIDTH-1]}}, cfg_bias});
        s1_shift <= cfg_shift;
      end
      s2_v <= s1_v;
      if (s1_v) begin
        s2_d <= sat[OUT_W-1:0];
        s2_l <= f_last;
        fcnt <= f_last ? '0 : fcnt + FW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s2_l, s2_d};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      ovf_err <= 1'b0;
    end else if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count   <= count + (AW+1)'(push) - (AW+1)'(pop);
      m_valid <= nxt_valid;
      if (nxt_valid) {m_last, m_data} <= mem[rd_ptr + AW'(pop)];
      ovf_err <= ovf_err | drop;
    end
  end
  assign fifo_level = count;
endmodule

// File: tb/tb_pe_post_proc.sv
// tb_pe_post_proc: directed and random checks of pe_post_proc against a queue-based reference model
module tb_pe_post_proc;
  localparam int OW = 8, FD = 8, FL = 16;
`ifdef PE_POST_RELU_EN
  localparam int EXP_NEG = 0, EXP_SAT = 255, EXP_MIN = 0;
`else
  localparam int EXP_NEG = 8'hE9, EXP_SAT = 127, EXP_MIN = 8'h80;
`endif
  logic        clk = 0, rst_n = 0, clr = 0, pe_ready = 0, m_ready = 0;
  logic [15:0] pe_data = 0, cfg_bias = 0;
  logic [3:0]  cfg_shift = 0;
  logic        m_valid, m_last, ovf_err;
  logic [7:0]  m_data;
  logic [3:0]  fifo_level;
  pe_post_proc #(.DATA_WIDTH(8), .OUT_W(OW), .FIFO_DEPTH(FD), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .pe_data(pe_data), .pe_ready(pe_ready),
    .cfg_bias(cfg_bias), .cfg_shift(cfg_shift), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .fifo_level(fifo_level), .ovf_err(ovf_err)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  typedef struct {int d; bit l;} res_t;
  res_t q[$];
  bit   p1_v, p2_v, p2_l, ev, el, ovf;
  int   p1_d, p2_d, fidx, ed;
  int   n_hs;
  int   last_pos[$];
  function automatic int ref_val(int d, int b, int s);
    int v;
    v = d + b;
`ifdef PE_POST_RELU_EN
    if (v < 0) v = 0;
    v = v >>> s;
    if (v > (1 << OW) - 1) v = (1 << OW) - 1;
`else
    v = v >>> s;
    if (v > (1 << (OW-1)) - 1) v = (1 << (OW-1)) - 1;
    if (v < -(1 << (OW-1))) v = -(1 << (OW-1));
`endif
    return v & ((1 << OW) - 1);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_clear();
    q.delete();
    p1_v = 0; p2_v = 0; fidx = 0; ev = 0; ovf = 0; ed = 0; el = 0;
  endtask
  task automatic check_all();
    chk("m_valid", {31'd0, m_valid}, {31'd0, ev});
    chk("fifo_level", {28'd0, fifo_level}, q.size());
    chk("ovf_err", {31'd0, ovf_err}, {31'd0, ovf});
    if (ev) begin
      chk("m_data", {24'd0, m_data}, ed);
      chk("m_last", {31'd0, m_last}, {31'd0, el});
    end
  endtask
  task automatic step();
    bit pop;
    if (ev && m_ready) begin
      n_hs++;
      if (m_last === 1'b1) last_pos.push_back(n_hs - 1);
    end
    @(posedge clk);
    if (clr) model_clear();
    else begin
      pop = ev && m_ready;
      if (pop) void'(q.pop_front());
      ev = q.size() != 0;
      if (ev) begin ed = q[0].d; el = q[0].l; end
      if (p2_v) begin
        if (q.size() == FD) ovf = 1;
        else q.push_back('{p2_d, p2_l});
      end
      p2_v = p1_v; p2_d = p1_d;
      if (p1_v) begin p2_l = (fidx == FL-1); fidx = (fidx + 1) % FL; end
      p1_v = pe_ready;
      p1_d = ref_val(int'(pe_data), int'($signed(cfg_bias)), int'(cfg_shift));
    end
    #1 check_all();
  endtask
  task automatic idle(input int n);
    repeat (n) step();
  endtask
  task automatic pulse(input int d, input int b, input int s);
    pe_ready = 1; pe_data = d[15:0]; cfg_bias = b[15:0]; cfg_shift = s[3:0];
    step();
    pe_ready = 0;
  endtask
  task automatic clear();
    clr = 1; step(); clr = 0;
  endtask
  task automatic do_reset();
    rst_n = 0;
    #2 model_clear();
    chk("rst_valid", {31'd0, m_valid}, 0);
    chk("rst_data", {24'd0, m_data}, 0);
    chk("rst_last", {31'd0, m_last}, 0);
    chk("rst_level", {28'd0, fifo_level}, 0);
    chk("rst_ovf", {31'd0, ovf_err}, 0);
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic one(input string tag, input int d, input int b, input int s, input int exp);
    pulse(d, b, s);
    step(); step();
    chk({tag, "_early"}, {31'd0, m_valid}, 0);
    step();
    chk({tag, "_valid"}, {31'd0, m_valid}, 1);
    chk({tag, "_data"}, {24'd0, m_data}, exp);
    idle(2);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    do_reset();
    clear();
    m_ready = 1;
    one("basic", 1000, -40, 4, 60);
    one("sign", 10, -100, 2, EXP_NEG);
    one("sat_hi", 65535, 0, 0, EXP_SAT);
    one("sat_lo", 0, -32768, 0, EXP_MIN);
    // overflow: 10 back-to-back with downstream stalled
    clear();
    m_ready = 0;
    for (int i = 0; i < 10; i++) pulse(i*10 + 5, 0, 0);
    idle(3);
    chk("ovf_level", {28'd0, fifo_level}, 8);
    chk("ovf_flag", {31'd0, ovf_err}, 1);
    chk("ovf_head", {24'd0, m_data}, 5);
    n_hs = 0; last_pos.delete();
    m_ready = 1;
    idle(12);
    chk("drain_count", n_hs, 8);
    // results 8,9 were dropped; result 15 is the 6th of the next six
    n_hs = 0; last_pos.delete();
    for (int i = 10; i < 16; i++) pulse(i, 0, 0);
    idle(6);
    chk("drop_last_n", last_pos.size(), 1);
    chk("drop_last_pos", last_pos.size() > 0 ? last_pos[0] : -1, 5);
    // frame tagging over 33 results
    clear();
    n_hs = 0; last_pos.delete();
    for (int i = 0; i < 33; i++) pulse($urandom_range(0, 65535), 0, 3);
    idle(6);
    chk("frame_n", n_hs, 33);
    chk("frame_lasts", last_pos.size(), 2);
    chk("frame_last0", last_pos.size() > 0 ? last_pos[0] : -1, 15);
    chk("frame_last1", last_pos.size() > 1 ? last_pos[1] : -1, 31);
    // clear with 4 buffered and 2 in flight, same cycle as a pulse
    m_ready = 0;
    for (int i = 0; i < 6; i++) pulse(i + 1, 0, 0);
    clr = 1; pe_ready = 1; m_ready = 1;
    step();
    clr = 0; pe_ready = 0;
    chk("clr_valid", {31'd0, m_valid}, 0);
    chk("clr_level", {28'd0, fifo_level}, 0);
    idle(6);
    chk("clr_stale", {31'd0, m_valid}, 0);
    // async reset with 4 buffered and 2 in flight
    m_ready = 0;
    for (int i = 0; i < 6; i++) pulse(i + 1, 0, 0);
    do_reset();
    idle(6);
    chk("rst_stale", {31'd0, m_valid}, 0);
    // random traffic
    for (int i = 0; i < 800; i++) begin
      pe_ready  = $urandom_range(0, 9) < 5;
      pe_data   = 16'($urandom);
      cfg_bias  = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($signed($urandom_range(0, 600)) - 300);
      cfg_shift = 4'($urandom_range(0, 15));
      m_ready   = $urandom_range(0, 9) < (i < 400 ? 6 : 3);
      clr       = $urandom_range(0, 199) == 0;
      step();
      if (i == 500) do_reset();
    end
    pe_ready = 0; clr = 0; m_ready = 1;
    idle(16);
    chk("final_level", {28'd0, fifo_level}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
